// File: rtl/ifetch_if.sv
// Fetch-stage bundle: instruction-memory handshake plus decoder-facing order/next-PC signals.
// master is the fetch unit; slave is the memory/decoder side.
interface ifetch_if;
   logic        im_req;
   logic [31:0] im_addr;
   logic        im_ack;
   logic [31:0] im_rdata;
   logic [31:0] order;
   logic        order_valid;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [1:0]  M1;
   logic        M5;
   logic [31:0] jr_target;
   logic        retire;
   logic        addr_err;
   logic        fetch_err;

   modport master (
      output im_req, im_addr, order, order_valid, pc, pc_plus4, addr_err, fetch_err,
      input  im_ack, im_rdata, M1, M5, jr_target, retire
   );

   modport slave (
      input  im_req, im_addr, order, order_valid, pc, pc_plus4, addr_err, fetch_err,
      output im_ack, im_rdata, M1, M5, jr_target, retire
   );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: holds the PC, fetches one word per instruction over a req/ack
// handshake with a retry timer, and computes the next PC when the decoder retires.
//
// state      | meaning
// RESET_WAIT | one idle cycle after reset, no request
// FETCH      | im_req high (except a one-cycle retry gap), waiting for im_ack
// ISSUE      | order valid and stable, waiting for retire
module ifetch_unit #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          ACK_TIMEOUT = 16
) (
   input  logic     clk,
   input  logic     rst_n,
   ifetch_if.master bus
);
   localparam int            TW         = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [TW-1:0] TIMER_LOAD = TW'(ACK_TIMEOUT - 1);

   typedef enum logic [1:0] {RESET_WAIT, FETCH, ISSUE} state_t;

   state_t        state;
   logic [31:0]   pc_q;
   logic [31:0]   order_q;
   logic          order_valid_q;
   logic          req_q;
   logic [TW-1:0] timer;
   logic          addr_err_q;
   logic          fetch_err_q;

   logic [31:0]   pc_plus4;
   logic [31:0]   br_off;
   logic [31:0]   next_pc;
   logic          jr_misaligned;

   assign pc_plus4      = pc_q + 32'd4;
   assign br_off        = {{14{order_q[15]}}, order_q[15:0], 2'b00};
   assign jr_misaligned = (bus.M1 == 2'b10) && (bus.jr_target[1:0] != 2'b00);

   always_comb begin
      next_pc = pc_plus4;
      case (bus.M1)
         2'b01:   next_pc = bus.M5 ? (pc_plus4 + br_off) : pc_plus4;
         2'b00:   next_pc = {pc_plus4[31:28], order_q[25:0], 2'b00};
         2'b10:   next_pc = {bus.jr_target[31:2], 2'b00};
         default: next_pc = pc_plus4;
      endcase
   end

   // Timer is a down-counter loaded on every request start; reaching zero while
   // still unacknowledged means ACK_TIMEOUT request cycles have elapsed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= RESET_WAIT;
         pc_q          <= RESET_PC;
         order_q       <= 32'd0;
         order_valid_q <= 1'b0;
         req_q         <= 1'b0;
         timer         <= '0;
         addr_err_q    <= 1'b0;
         fetch_err_q   <= 1'b0;
      end else begin
         case (state)
            RESET_WAIT: begin
               state <= FETCH;
               req_q <= 1'b1;
               timer <= TIMER_LOAD;
            end
            FETCH: begin
               if (req_q) begin
                  if (bus.im_ack) begin
                     order_q       <= bus.im_rdata;
                     order_valid_q <= 1'b1;
                     req_q         <= 1'b0;
                     state         <= ISSUE;
                  end else if (timer == '0) begin
                     fetch_err_q <= 1'b1;
                     req_q       <= 1'b0;
                  end else begin
                     timer <= timer - TW'(1);
                  end
               end else begin
                  // retry gap: request dropped for exactly this one cycle
                  req_q <= 1'b1;
                  timer <= TIMER_LOAD;
               end
            end
            ISSUE: begin
               if (bus.retire) begin
                  pc_q          <= next_pc;
                  order_valid_q <= 1'b0;
                  req_q         <= 1'b1;
                  timer         <= TIMER_LOAD;
                  state         <= FETCH;
                  if (jr_misaligned) addr_err_q <= 1'b1;
               end
            end
            default: state <= RESET_WAIT;
         endcase
      end
   end

   assign bus.im_req      = req_q;
   assign bus.im_addr     = pc_q;
   assign bus.order       = order_q;
   assign bus.order_valid = order_valid_q;
   assign bus.pc          = pc_q;
   assign bus.pc_plus4    = pc_plus4;
   assign bus.addr_err    = addr_err_q;
   assign bus.fetch_err   = fetch_err_q;
endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed scenarios plus a randomized instruction
// stream checked against an arithmetic next-PC model.
module tb_ifetch_unit;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   logic [31:0] exp_pc;
   logic [31:0] exp_order;
   logic        exp_aerr;
   logic        exp_ferr;

   ifetch_if bus ();

   ifetch_unit #(.RESET_PC(32'h0000_0000), .ACK_TIMEOUT(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] ord,
                                              input logic [1:0] m1, input logic m5,
                                              input logic [31:0] jt);
      int          imm;
      logic [31:0] r;
      imm = int'($signed(ord[15:0]));
      case (m1)
         2'b01:   r = m5 ? (p + 32'd4 + 32'(imm * 4)) : (p + 32'd4);
         2'b00:   r = ((p + 32'd4) & 32'hF000_0000) | ((ord & 32'h03FF_FFFF) * 32'd4);
         2'b10:   r = jt & 32'hFFFF_FFFC;
         default: r = p + 32'd4;
      endcase
      return r;
   endfunction

   task automatic do_fetch(input logic [31:0] word, input int dly);
      repeat (dly) @(negedge clk);
      bus.im_ack   = 1'b1;
      bus.im_rdata = word;
      @(negedge clk);
      bus.im_ack   = 1'b0;
      bus.im_rdata = $urandom;
      exp_order    = word;
   endtask

   task automatic do_retire(input logic [1:0] m1, input logic m5, input logic [31:0] jt, input int dly);
      logic [31:0] nxt;
      repeat (dly) @(negedge clk);
      nxt = model_next(exp_pc, exp_order, m1, m5, jt);
      if (m1 == 2'b10 && (jt & 32'd3) != 32'd0) exp_aerr = 1'b1;
      bus.retire    = 1'b1;
      bus.M1        = m1;
      bus.M5        = m5;
      bus.jr_target = jt;
      @(negedge clk);
      bus.retire    = 1'b0;
      bus.M1        = 2'($urandom);
      bus.M5        = 1'($urandom);
      bus.jr_target = $urandom;
      exp_pc        = nxt;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (bus.im_req !== 1'b0) begin errors++; $display("FAIL rst_im_req got %b exp 0", bus.im_req); end
      checks++; if (bus.im_addr !== 32'h0) begin errors++; $display("FAIL rst_im_addr got %h exp 0", bus.im_addr); end
      checks++; if (bus.order !== 32'h0) begin errors++; $display("FAIL rst_order got %h exp 0", bus.order); end
      checks++; if (bus.order_valid !== 1'b0) begin errors++; $display("FAIL rst_order_valid got %b exp 0", bus.order_valid); end
      checks++; if (bus.pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h exp 0", bus.pc); end
      checks++; if (bus.addr_err !== 1'b0 || bus.fetch_err !== 1'b0) begin errors++; $display("FAIL rst_errs got %b%b exp 00", bus.addr_err, bus.fetch_err); end
   endtask

   task automatic test_first_fetch;
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (bus.im_req !== 1'b1 || bus.im_addr !== 32'h0) begin errors++; $display("FAIL first_req got req=%b addr=%h exp req=1 addr=0", bus.im_req, bus.im_addr); end
      do_fetch(32'h2401_0005, 0);
      exp_pc = 32'h0;
      checks++; if (bus.order !== 32'h2401_0005) begin errors++; $display("FAIL first_order got %h exp 24010005", bus.order); end
      checks++; if (bus.order_valid !== 1'b1 || bus.im_req !== 1'b0) begin errors++; $display("FAIL first_valid got v=%b req=%b exp v=1 req=0", bus.order_valid, bus.im_req); end
      checks++; if (bus.pc !== 32'h0 || bus.pc_plus4 !== 32'h4) begin errors++; $display("FAIL first_pc got %h/%h exp 0/4", bus.pc, bus.pc_plus4); end
   endtask

   task automatic test_branch;
      do_retire(2'b01, 1'b0, 32'h0, 1);
      checks++; if (bus.im_req !== 1'b1 || bus.im_addr !== 32'h4) begin errors++; $display("FAIL seq_addr got req=%b addr=%h exp 1/4", bus.im_req, bus.im_addr); end
      do_fetch(32'h0800_0040, 1);
      do_retire(2'b00, 1'b0, 32'h0, 0);
      checks++; if (bus.im_addr !== 32'h100) begin errors++; $display("FAIL j_addr got %h exp 100", bus.im_addr); end
      do_fetch(32'h1000_FFFE, 0);
      do_retire(2'b01, 1'b1, 32'h0, 0);
      checks++; if (bus.im_req !== 1'b1 || bus.im_addr !== 32'h0FC) begin errors++; $display("FAIL br_taken got req=%b addr=%h exp 1/fc", bus.im_req, bus.im_addr); end
      do_fetch(32'h0800_0040, 2);
      do_retire(2'b00, 1'b0, 32'h0, 0);
      do_fetch(32'h1000_FFFE, 0);
      do_retire(2'b01, 1'b0, 32'h0, 1);
      checks++; if (bus.im_addr !== 32'h104) begin errors++; $display("FAIL br_not_taken got %h exp 104", bus.im_addr); end
   endtask

   task automatic test_jump_jr;
      do_fetch(32'h0, 0);
      do_retire(2'b10, 1'b0, 32'h8000_0000, 0);
      checks++; if (bus.im_addr !== 32'h8000_0000 || bus.addr_err !== 1'b0) begin errors++; $display("FAIL jr_aligned got addr=%h aerr=%b exp 80000000/0", bus.im_addr, bus.addr_err); end
      do_fetch(32'h0800_0040, 1);
      do_retire(2'b00, 1'b0, 32'h0, 0);
      checks++; if (bus.im_addr !== 32'h8000_0100) begin errors++; $display("FAIL j_upper got %h exp 80000100", bus.im_addr); end
      do_fetch(32'h0, 0);
      do_retire(2'b10, 1'b0, 32'h0000_1237, 0);
      checks++; if (bus.im_addr !== 32'h1234 || bus.addr_err !== 1'b1) begin errors++; $display("FAIL jr_misaligned got addr=%h aerr=%b exp 1234/1", bus.im_addr, bus.addr_err); end
      do_fetch(32'h0, 0);
      do_retire(2'b10, 1'b0, 32'hFFFF_FFFC, 0);
      checks++; if (bus.im_addr !== 32'hFFFF_FFFC || bus.addr_err !== 1'b1) begin errors++; $display("FAIL aerr_sticky got addr=%h aerr=%b exp fffffffc/1", bus.im_addr, bus.addr_err); end
   endtask

   task automatic test_wrap;
      do_fetch(32'h0, 0);
      checks++; if (bus.pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_plus4 got %h exp 0", bus.pc_plus4); end
      do_retire(2'b01, 1'b0, 32'h0, 0);
      checks++; if (bus.im_req !== 1'b1 || bus.im_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr got req=%b addr=%h exp 1/0", bus.im_req, bus.im_addr); end
   endtask

   task automatic test_timeout;
      int bad;
      bad = 0;
      for (int i = 0; i < 16; i++) begin
         if (bus.im_req !== 1'b1 || bus.fetch_err !== 1'b0) bad++;
         @(negedge clk);
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL to_wait got %0d bad cycles exp 0", bad); end
      checks++; if (bus.im_req !== 1'b0 || bus.fetch_err !== 1'b1) begin errors++; $display("FAIL to_gap got req=%b ferr=%b exp 0/1", bus.im_req, bus.fetch_err); end
      exp_ferr = 1'b1;
      @(negedge clk);
      checks++; if (bus.im_req !== 1'b1 || bus.im_addr !== exp_pc) begin errors++; $display("FAIL to_rereq got req=%b addr=%h exp 1/%h", bus.im_req, bus.im_addr, exp_pc); end
      do_fetch(32'hA5A5_0001, 2);
      checks++; if (bus.order !== 32'hA5A5_0001 || bus.order_valid !== 1'b1) begin errors++; $display("FAIL to_ack got %h v=%b exp a5a50001 v=1", bus.order, bus.order_valid); end
   endtask

   task automatic test_ignore_priority;
      bus.im_ack = 1'b1; bus.im_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      bus.im_ack = 1'b0;
      checks++; if (bus.order !== exp_order || bus.order_valid !== 1'b1) begin errors++; $display("FAIL issue_ack_ignored got %h v=%b exp %h v=1", bus.order, bus.order_valid, exp_order); end
      do_retire(2'b01, 1'b0, 32'h0, 0);
      for (int i = 0; i < 15; i++) begin
         bus.retire = (i == 5);
         bus.M1 = 2'b10; bus.jr_target = 32'h0000_4444;
         @(negedge clk);
         bus.retire = 1'b0;
      end
      checks++; if (bus.im_req !== 1'b1 || bus.im_addr !== exp_pc) begin errors++; $display("FAIL fetch_retire_ignored got req=%b addr=%h exp 1/%h", bus.im_req, bus.im_addr, exp_pc); end
      do_fetch(32'h1234_5678, 0);
      checks++; if (bus.order !== 32'h1234_5678 || bus.order_valid !== 1'b1) begin errors++; $display("FAIL ack_on_timeout got %h v=%b exp 12345678 v=1", bus.order, bus.order_valid); end
   endtask

   task automatic test_random;
      logic [31:0] w;
      logic [1:0]  m1;
      logic [31:0] jt;
      int          bad_issue, bad_fetch;
      bad_issue = 0; bad_fetch = 0;
      for (int n = 0; n < 150; n++) begin
         m1 = 2'($urandom);
         jt = $urandom;
         do_retire(m1, 1'($urandom), jt, $urandom_range(0, 2));
         if (bus.im_req !== 1'b1 || bus.im_addr !== exp_pc || bus.order_valid !== 1'b0 ||
             bus.addr_err !== exp_aerr || bus.fetch_err !== exp_ferr) begin
            bad_fetch++;
            if (bad_fetch < 5) $display("FAIL rnd_fetch got addr=%h aerr=%b exp addr=%h aerr=%b", bus.im_addr, bus.addr_err, exp_pc, exp_aerr);
         end
         w = $urandom;
         do_fetch(w, $urandom_range(0, 3));
         if (bus.order !== w || bus.order_valid !== 1'b1 || bus.pc !== exp_pc || bus.pc_plus4 !== exp_pc + 32'd4) begin
            bad_issue++;
            if (bad_issue < 5) $display("FAIL rnd_issue got order=%h pc=%h exp order=%h pc=%h", bus.order, bus.pc, w, exp_pc);
         end
      end
      checks++; if (bad_fetch != 0) begin errors++; $display("FAIL rnd_fetch_total got %0d exp 0", bad_fetch); end
      checks++; if (bad_issue != 0) begin errors++; $display("FAIL rnd_issue_total got %0d exp 0", bad_issue); end
   endtask

   task automatic test_reset_midfetch;
      do_retire(2'b01, 1'b0, 32'h0, 0);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++; if (bus.im_req !== 1'b0 || bus.im_addr !== 32'h0 || bus.pc !== 32'h0) begin errors++; $display("FAIL mid_rst_pc got req=%b addr=%h exp 0/0", bus.im_req, bus.im_addr); end
      checks++; if (bus.order !== 32'h0 || bus.order_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_order got %h v=%b exp 0 v=0", bus.order, bus.order_valid); end
      checks++; if (bus.addr_err !== 1'b0 || bus.fetch_err !== 1'b0) begin errors++; $display("FAIL mid_rst_errs got %b%b exp 00", bus.addr_err, bus.fetch_err); end
      bus.im_ack = 1'b1; bus.im_rdata = 32'hCAFE_F00D;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      bus.im_ack = 1'b0;
      exp_pc = 32'h0; exp_aerr = 1'b0; exp_ferr = 1'b0;
      checks++; if (bus.order_valid !== 1'b0 || bus.im_req !== 1'b1 || bus.im_addr !== 32'h0) begin errors++; $display("FAIL post_rst_ack_ignored got v=%b req=%b addr=%h exp 0/1/0", bus.order_valid, bus.im_req, bus.im_addr); end
      do_fetch(32'h0BAD_CAFE, 1);
      checks++; if (bus.order !== 32'h0BAD_CAFE || bus.pc !== 32'h0 || bus.order_valid !== 1'b1) begin errors++; $display("FAIL post_rst_fetch got %h pc=%h exp 0badcafe pc=0", bus.order, bus.pc); end
   endtask

   initial begin
      checks = 0; errors = 0;
      exp_pc = 32'h0; exp_order = 32'h0; exp_aerr = 1'b0; exp_ferr = 1'b0;
      rst_n = 1'b0;
      bus.im_ack = 1'b0; bus.im_rdata = 32'h0; bus.M1 = 2'b01; bus.M5 = 1'b0;
      bus.jr_target = 32'h0; bus.retire = 1'b0;
      test_reset;
      test_first_fetch;
      test_branch;
      test_jump_jr;
      test_wrap;
      test_timeout;
      test_ignore_priority;
      test_random;
      test_reset_midfetch;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end
endmodule
